// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed CHUNK bits per clock,
// LSB chunk first, with a registered carry between chunks.

module serial_chunk_adder_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  logic [W:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[W];
  // carry into the top bit of this chunk; only meaningful on the final chunk
  assign cmsb = c[W-1];
endmodule

module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int STEPS = WIDTH / CHUNK;
  localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("serial_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] opa, opb, res, res_next;
  logic             cy;
  logic [IW-1:0]    idx;
  logic             accept, last;
  logic [CHUNK-1:0] csum;
  logic             cout, cmsb;

  // operands shift right each step so the active chunk is always at the bottom
  serial_chunk_adder_rca #(.W(CHUNK)) u_rca (
    .x    (opa[CHUNK-1:0]),
    .y    (opb[CHUNK-1:0]),
    .cin  (cy),
    .sum  (csum),
    .cout (cout),
    .cmsb (cmsb)
  );

  always_comb begin
    res_next = res >> CHUNK;
    res_next[WIDTH-1 -: CHUNK] = csum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (idx == IW'(STEPS - 1)) begin
        last    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa  <= '0;
      opb  <= '0;
      res  <= '0;
      cy   <= 1'b0;
      idx  <= '0;
      done <= 1'b0;
      s    <= '0;
      co   <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        opa <= a;
        opb <= b ^ {WIDTH{sub}};
        cy  <= ci ^ sub;
        idx <= '0;
      end else if (state_q == RUN) begin
        opa <= opa >> CHUNK;
        opb <= opb >> CHUNK;
        cy  <= cout;
        idx <= idx + IW'(1);
        res <= res_next;
        if (last) begin
          s   <= res_next;
          co  <= cout;
          ovf <= cout ^ cmsb;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: three instances (CHUNK=4,16,1) checked every cycle
// against an arithmetic model, plus directed literal expectations.

module tb_serial_chunk_adder;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       start_v;
  logic             sub, ci;
  logic [15:0]      a, b;
  logic [2:0]       busy_v, done_v, co_v, ovf_v;
  logic [2:0][15:0] s_v;

  int checks = 0;
  int errors = 0;

  // model state per instance
  bit          m_busy[3], m_done[3], m_co[3], m_ovf[3], p_co[3], p_ovf[3];
  logic [15:0] m_s[3], p_s[3];
  int          cnt[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    serial_chunk_adder #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[g]),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .s     (s_v[g]),
      .co    (co_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  function automatic int steps_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // result straight from integer arithmetic on the operand values
  task automatic calc(input bit sb, input logic [15:0] x, input logic [15:0] y, input bit c,
                      output logic [15:0] r, output bit cout, output bit ov);
    int u, sv;
    if (!sb) begin
      u  = int'(x) + int'(y) + int'(c);
      sv = int'($signed(x)) + int'($signed(y)) + int'(c);
    end else begin
      u  = int'(x) + (65535 - int'(y)) + (c ? 0 : 1);
      sv = int'($signed(x)) - int'($signed(y)) - int'(c);
    end
    r    = u[15:0];
    cout = (u > 65535);
    ov   = (sv > 32767) || (sv < -32768);
  endtask

  task automatic op(input bit sb, input logic [15:0] x, input logic [15:0] y, input bit c,
                    input logic [15:0] es, input bit eco, input bit eov, input string nm);
    int dcyc[3];
    int nb[3];
    sub = sb; a = x; b = y; ci = c; start_v = 3'b111;
    @(posedge clk); #1;
    start_v = 3'b000;
    for (int g = 0; g < 3; g++) begin dcyc[g] = 0; nb[g] = 0; end
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      for (int g = 0; g < 3; g++) begin
        if (busy_v[g]) nb[g]++;
        if (done_v[g] && dcyc[g] == 0) dcyc[g] = k;
      end
      if (dcyc[0] != 0 && dcyc[1] != 0 && dcyc[2] != 0) break;
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s c%0d latency", nm, g), dcyc[g], steps_of(g));
      chk($sformatf("%s c%0d busy_cycles", nm, g), nb[g], steps_of(g));
      chk($sformatf("%s c%0d s", nm, g), s_v[g], es);
      chk($sformatf("%s c%0d co", nm, g), co_v[g], eco);
      chk($sformatf("%s c%0d ovf", nm, g), ovf_v[g], eov);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      m_busy[g] = 0; m_done[g] = 0; m_co[g] = 0; m_ovf[g] = 0; m_s[g] = '0; cnt[g] = 0;
    end
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
              m_busy[g] = 0; m_done[g] = 0; m_co[g] = 0; m_ovf[g] = 0; m_s[g] = '0; cnt[g] = 0;
            end
            chk($sformatf("mdl c%0d busy", g), busy_v[g], m_busy[g]);
            chk($sformatf("mdl c%0d done", g), done_v[g], m_done[g]);
            chk($sformatf("mdl c%0d s", g), s_v[g], m_s[g]);
            chk($sformatf("mdl c%0d co", g), co_v[g], m_co[g]);
            chk($sformatf("mdl c%0d ovf", g), ovf_v[g], m_ovf[g]);
            if (rst_n) begin
              m_done[g] = 0;
              if (m_busy[g]) begin
                cnt[g]--;
                if (cnt[g] == 0) begin
                  m_busy[g] = 0; m_done[g] = 1;
                  m_s[g] = p_s[g]; m_co[g] = p_co[g]; m_ovf[g] = p_ovf[g];
                end
              end else if (start_v[g]) begin
                m_busy[g] = 1;
                cnt[g] = steps_of(g);
                calc(sub, a, b, ci, p_s[g], p_co[g], p_ovf[g]);
              end
            end
          end
        end
      end
      begin : stim
        int prevk, nd;
        rst_n = 1'b0; start_v = 3'b000; a = '0; b = '0; sub = 1'b0; ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy_v, 3'b000);
        chk("rst done", done_v, 3'b000);
        chk("rst s0", s_v[0], 16'h0000);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add1");
        op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
        op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        op(1'b0, 16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0, "add_ci");
        op(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        op(1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, 1'b0, 1'b0, "sub_borrow");

        // start and operand churn while busy must not disturb the latched op
        sub = 1'b0; a = 16'h1111; b = 16'h2222; ci = 1'b0; start_v = 3'b001;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
          chk("hs s_hold", s_v[0], 16'hFFFD);
          chk("hs busy", busy_v[0], 1'b1);
          a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); ci = 1'($urandom);
          start_v = {2'b00, (k != 1)};
          @(posedge clk); #1;
        end
        start_v = 3'b000;
        chk("hs done", done_v[0], 1'b1);
        chk("hs busy_after", busy_v[0], 1'b0);
        chk("hs s", s_v[0], 16'h3333);

        // start held high: one result every STEPS+1 cycles
        sub = 1'b0; a = 16'h0001; b = 16'h0001; ci = 1'b0; start_v = 3'b111;
        prevk = -1; nd = 0;
        for (int k = 1; k <= 22; k++) begin
          @(posedge clk); #1;
          if (done_v[0]) begin
            nd++;
            if (prevk >= 0) chk("thru gap", k - prevk, 5);
            prevk = k;
          end
        end
        chk("thru count", nd, 4);
        start_v = 3'b000;
        repeat (20) @(posedge clk);
        #1;

        // asynchronous reset in the middle of an operation
        a = 16'h1234; b = 16'h4321; sub = 1'b0; ci = 1'b0; start_v = 3'b111;
        @(posedge clk); #1 start_v = 3'b000;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst busy", busy_v, 3'b000);
        chk("arst done", done_v, 3'b000);
        for (int g = 0; g < 3; g++) chk($sformatf("arst c%0d s", g), s_v[g], 16'h0000);
        chk("arst co", co_v, 3'b000);
        chk("arst ovf", ovf_v, 3'b000);
        @(negedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(posedge clk); #1;
          chk("arst no_done", done_v, 3'b000);
        end
        op(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst");
        repeat (2) @(posedge clk);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
